// File: rtl/div_norm.sv
// -----------------------------------------------------------------------------
// div_norm
// Operand pre-normalisation stage for the 9-bit convergence divider.
// The stage accepts an unsigned N/D pair. It left-shifts D one bit per cycle
// until the MSB of D reaches bit W-1, so the divider always sees
// 2^(W-1) <= d <= 2^W-1. It reports the shift count k, which lets a
// downstream denormaliser recover N/D = q * 2^k / 2^W.
//
// Ports
//   clk        in   1     system clock, rising edge
//   reset      in   1     synchronous, active-low reset
//   in_valid   in   1     operand pair present on n_in/d_in
//   in_ready   out  1     stage can accept an operand pair (IDLE)
//   n_in       in   W     unsigned nominator N
//   d_in       in   W     unsigned denominator D
//   out_valid  out  1     normalised result present (DONE)
//   out_ready  in   1     downstream consumes the result
//   n_out      out  W+1   zero-extended N
//   d_out      out  W+1   zero-extended D<<k
//   shift      out  CW    k, number of left shifts applied to D
//   div_zero   out  1     D was 0, result invalid for division
// -----------------------------------------------------------------------------
module div_norm #(
    parameter int unsigned W  = 8,
    parameter int unsigned CW = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  n_in,
    input  logic [W-1:0]  d_in,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W:0]    n_out,
    output logic [W:0]    d_out,
    output logic [CW-1:0] shift,
    output logic          div_zero
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    state_e        state_q, state_d;

    // Working copies of the accepted operands.
    logic [W-1:0]  n_reg_q, n_reg_d;
    logic [W-1:0]  d_reg_q, d_reg_d;
    logic [CW-1:0] cnt_q,   cnt_d;

    // Result registers. They are written only on DONE entry and hold their
    // values through IDLE/SHIFT, so the divider can sample them freely.
    logic [W:0]    n_out_q,    n_out_d;
    logic [W:0]    d_out_q,    d_out_d;
    logic [CW-1:0] shift_q,    shift_d;
    logic          div_zero_q, div_zero_d;

    // -------------------------------------------------------------------------
    // State register (plus datapath registers)
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            n_reg_q    <= '0;
            d_reg_q    <= '0;
            cnt_q      <= '0;
            n_out_q    <= '0;
            d_out_q    <= '0;
            shift_q    <= '0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            n_reg_q    <= n_reg_d;
            d_reg_q    <= d_reg_d;
            cnt_q      <= cnt_d;
            n_out_q    <= n_out_d;
            d_out_q    <= d_out_d;
            shift_q    <= shift_d;
            div_zero_q <= div_zero_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    // A zero divisor can never be normalised, so it skips
                    // the shift loop entirely.
                    state_d = (d_in == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                if (d_reg_q[W-1]) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                // in_valid is deliberately ignored here. The next accept
                // happens one edge later, in IDLE.
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        n_reg_d    = n_reg_q;
        d_reg_d    = d_reg_q;
        cnt_d      = cnt_q;
        n_out_d    = n_out_q;
        d_out_d    = d_out_q;
        shift_d    = shift_q;
        div_zero_d = div_zero_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    n_reg_d = n_in;
                    d_reg_d = d_in;
                    cnt_d   = '0;
                    if (d_in == '0) begin
                        n_out_d    = {1'b0, n_in};
                        d_out_d    = '0;
                        shift_d    = '0;
                        div_zero_d = 1'b1;
                    end
                end
            end
            SHIFT: begin
                if (d_reg_q[W-1]) begin
                    n_out_d    = {1'b0, n_reg_q};
                    d_out_d    = {1'b0, d_reg_q};
                    shift_d    = cnt_q;
                    div_zero_d = 1'b0;
                end else begin
                    // The loop exits as soon as the MSB is set. The shift
                    // therefore never drops a one, and cnt stops at W-1.
                    d_reg_d = d_reg_q << 1;
                    cnt_d   = cnt_q + 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Output logic. The handshake flags are pure decodes of the state register.
    // -------------------------------------------------------------------------
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
    end

    assign n_out    = n_out_q;
    assign d_out    = d_out_q;
    assign shift    = shift_q;
    assign div_zero = div_zero_q;

    // -------------------------------------------------------------------------
    // Output invariants
    // -------------------------------------------------------------------------
    a_norm_range: assert property (@(posedge clk) disable iff (!reset)
        (out_valid && !div_zero) |-> d_out[W-1]);

    a_zero_result: assert property (@(posedge clk) disable iff (!reset)
        (out_valid && div_zero) |-> (d_out == '0 && shift == '0));

    a_msb_clear: assert property (@(posedge clk) disable iff (!reset)
        (!n_out[W] && !d_out[W]));

    a_handshake_excl: assert property (@(posedge clk) disable iff (!reset)
        !(in_ready && out_valid));

endmodule

// File: tb/tb_div_norm.sv
// -----------------------------------------------------------------------------
// tb_div_norm
// Scoreboard bench for div_norm. A negedge monitor pushes an expected result
// for every accepted operand pair. It pops and compares that result when
// out_valid first rises, including the latency. It then checks that the
// outputs stay stable while out_valid is held.
// -----------------------------------------------------------------------------
module tb_div_norm;

    localparam int unsigned W  = 8;
    localparam int unsigned CW = 3;

    typedef struct {
        logic [W:0]    n;
        logic [W:0]    d;
        logic [CW-1:0] k;
        logic          dz;
        int            lat;
        int            acc_cyc;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  n_in;
    logic [W-1:0]  d_in;
    logic          out_valid;
    logic          out_ready;
    logic [W:0]    n_out;
    logic [W:0]    d_out;
    logic [CW-1:0] shift;
    logic          div_zero;

    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc      = 0;
    exp_t sb_q[$];
    exp_t cur;
    bit   seen     = 1'b0;

    div_norm #(.W(W), .CW(CW)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .n_in      (n_in),
        .d_in      (d_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .n_out     (n_out),
        .d_out     (d_out),
        .shift     (shift),
        .div_zero  (div_zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference model: count leading zeros and normalise.
    function automatic exp_t model(input logic [W-1:0] n, input logic [W-1:0] d);
        exp_t e;
        int   k = 0;
        for (int i = W - 1; i >= 0; i--) begin
            if (d[i]) break;
            k++;
        end
        e.n = {1'b0, n};
        if (d == '0) begin
            e.d   = '0;
            e.k   = '0;
            e.dz  = 1'b1;
            e.lat = 0;
        end else begin
            e.d   = {1'b0, d << k};
            e.k   = k[CW-1:0];
            e.dz  = 1'b0;
            e.lat = k + 1;
        end
        e.acc_cyc = 0;
        return e;
    endfunction

    // Monitor. Inputs change at posedge+2, so at negedge both the inputs and
    // the DUT outputs are stable.
    always @(negedge clk) begin
        if (!reset) begin
            sb_q.delete();
            seen = 1'b0;
        end else begin
            if (in_valid && in_ready) begin
                exp_t e;
                e = model(n_in, d_in);
                e.acc_cyc = cyc + 1;
                sb_q.push_back(e);
            end
            if (out_valid) begin
                if (!seen) begin
                    if (sb_q.size() == 0) begin
                        check("unexpected_out_valid", 1, 0);
                    end else begin
                        cur = sb_q.pop_front();
                        check("n_out",    n_out,    cur.n);
                        check("d_out",    d_out,    cur.d);
                        check("shift",    shift,    cur.k);
                        check("div_zero", div_zero, cur.dz);
                        check("latency",  cyc - cur.acc_cyc, cur.lat);
                        check("in_ready_in_done", in_ready, 0);
                    end
                    seen = 1'b1;
                end else begin
                    check("hold_n_out", n_out, cur.n);
                    check("hold_d_out", d_out, cur.d);
                    check("hold_shift", shift, cur.k);
                    check("hold_dz",    div_zero, cur.dz);
                end
                if (out_ready) seen = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Present an operand pair and hold it until the stage accepts it.
    task automatic send(input logic [W-1:0] n, input logic [W-1:0] d);
        bit acc = 1'b0;
        in_valid = 1'b1;
        n_in     = n;
        d_in     = d;
        for (int i = 0; i < 50 && !acc; i++) begin
            acc = in_ready;
            tick();
        end
        if (!acc) check("accept_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        bit done = 1'b0;
        for (int i = 0; i < 50 && !done; i++) begin
            if (sb_q.size() == 0 && !out_valid) done = 1'b1;
            else tick();
        end
        if (!done) check("drain_timeout", 0, 1);
    endtask

    initial begin
        reset     = 1'b0;
        in_valid  = 1'b1;
        n_in      = 8'd5;
        d_in      = 8'd5;
        out_ready = 1'b1;
        tick();
        tick();
        check("rst_in_ready",  in_ready,  1);
        check("rst_out_valid", out_valid, 0);
        check("rst_n_out",     n_out,     0);
        check("rst_d_out",     d_out,     0);
        check("rst_shift",     shift,     0);
        check("rst_div_zero",  div_zero,  0);
        reset = 1'b1;

        send(8'd200, 8'd200); drain();
        send(8'd255, 8'd1);   drain();
        send(8'd100, 8'd3);   drain();
        send(8'd77,  8'd0);   drain();
        send(8'd10,  8'd64);  drain();

        // Backpressure: hold the result while a new operand is waiting.
        out_ready = 1'b0;
        send(8'd33, 8'd16);
        for (int i = 0; i < 20 && !out_valid; i++) tick();
        check("bp_out_valid_rise", out_valid, 1);
        in_valid = 1'b1;
        n_in     = 8'd1;
        d_in     = 8'd1;
        for (int i = 0; i < 5; i++) begin
            check("bp_in_ready_low", in_ready,  0);
            check("bp_out_valid",    out_valid, 1);
            tick();
        end
        out_ready = 1'b1;
        send(8'd1, 8'd1);
        drain();

        // Reset in the middle of a shift.
        send(8'd9, 8'd1);
        tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("mid_rst_in_ready",  in_ready,  1);
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_d_out",     d_out,     0);
        check("mid_rst_shift",     shift,     0);
        check("mid_rst_n_out",     n_out,     0);
        for (int i = 0; i < 10; i++) begin
            check("mid_rst_no_out", out_valid, 0);
            tick();
        end
        send(8'd4, 8'd2); drain();

        // Random operands, including an occasional zero divisor.
        for (int i = 0; i < 12; i++) begin
            logic [W-1:0] rn, rd;
            rn = W'($urandom_range(0, 255));
            rd = (i % 5 == 0) ? '0 : W'($urandom_range(0, 255));
            send(rn, rd);
            drain();
        end

        check("scoreboard_empty", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
